// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, load/store size codes, MEM FSM encoding,
// and the pipeline-register payload types.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] storeData;
  } exMem_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            regWrite;
    logic [XLEN-1:0] data;
  } memWb_t;

  // Halfwords need an even address, words a multiple of four; bytes are always aligned.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (funct3[1:0])
      2'b01:   bad = addrLo[0];
      2'b10:   bad = |addrLo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Data-memory lane handling: load lane select with sign/zero extension,
// store byte enables and lane replication.
module load_align
  import core_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addrLo,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] storeData,
  output logic [XLEN-1:0] loadData,
  output logic [3:0]      byteEn,
  output logic [XLEN-1:0] wdata
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    laneByte = rdata[7:0];
    laneHalf = addrLo[1] ? rdata[31:16] : rdata[15:0];
    case (addrLo)
      2'd1:    laneByte = rdata[15:8];
      2'd2:    laneByte = rdata[23:16];
      2'd3:    laneByte = rdata[31:24];
      default: laneByte = rdata[7:0];
    endcase
  end

  // funct3[2] selects zero extension (BU/HU)
  always_comb begin
    loadData = rdata;
    case (funct3[1:0])
      2'b00:   loadData = {{24{laneByte[7] & ~funct3[2]}}, laneByte};
      2'b01:   loadData = {{16{laneHalf[15] & ~funct3[2]}}, laneHalf};
      default: loadData = rdata;
    endcase
  end

  always_comb begin
    byteEn = 4'b1111;
    wdata  = storeData;
    case (funct3[1:0])
      2'b00: begin
        byteEn = 4'(4'b0001 << addrLo);
        wdata  = {4{storeData[7:0]}};
      end
      2'b01: begin
        byteEn = 4'(4'b0011 << addrLo);
        wdata  = {2{storeData[15:0]}};
      end
      default: begin
        byteEn = 4'b1111;
        wdata  = storeData;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the MEM-stage data-memory sequencer.
// Supplies MEM/WB destination info and values to the forwarding unit.
module mem_wb_pipe #(
  parameter int unsigned XLEN = core_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_mem,
  output logic            misalign,
  output logic [4:0]      rdAddr_mem,
  output logic            RegWrite_mem,
  output logic [XLEN-1:0] fwd_mem_data,
  output logic [4:0]      rdAddr_wb,
  output logic            RegWrite_wb,
  output logic [XLEN-1:0] wb_data
);
  import core_pkg::*;

  exMem_t     memQ;
  memWb_t     wbQ;
  logic [0:0] state;
  logic [0:0] stateNext;
  logic       exGo;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] storeWdata;
  logic [3:0]      storeBe;

  assign exGo = ex_valid & (ex_mem_read | ex_mem_write)
              & ~isMisaligned(ex_funct3, ex_alu_result[1:0]);

  // EX/MEM register: advances whenever MEM is not waiting on memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memQ <= '0;
    end else if (!stall_mem) begin
      memQ.valid     <= ex_valid;
      memQ.rd        <= ex_rd_addr;
      memQ.regWrite  <= ex_reg_write;
      memQ.memRead   <= ex_mem_read;
      memQ.memWrite  <= ex_mem_write;
      memQ.funct3    <= ex_funct3;
      memQ.alu       <= ex_alu_result;
      memQ.storeData <= ex_store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // ACCESS is entered on the same edge the mem op lands in EX/MEM, so the request leaves with no bubble
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (exGo) stateNext = ACCESS;
      ACCESS:  if (dmem_ready) stateNext = exGo ? ACCESS : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  load_align u_load_align (
    .funct3    (memQ.funct3),
    .addrLo    (memQ.alu[1:0]),
    .rdata     (dmem_rdata),
    .storeData (memQ.storeData),
    .loadData  (loadData),
    .byteEn    (storeBe),
    .wdata     (storeWdata)
  );

  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = dmem_req & memQ.memWrite;
  assign dmem_be    = dmem_req ? storeBe : 4'b0000;
  assign dmem_addr  = {memQ.alu[XLEN-1:2], 2'b00};
  assign dmem_wdata = storeWdata;
  assign stall_mem  = dmem_req & ~dmem_ready;

  assign misalign = memQ.valid & (memQ.memRead | memQ.memWrite)
                  & isMisaligned(memQ.funct3, memQ.alu[1:0]);

  assign rdAddr_mem   = memQ.rd;
  assign RegWrite_mem = memQ.valid & memQ.regWrite & ~misalign;
  assign fwd_mem_data = memQ.alu;

  // MEM/WB register: stalled or misaligned MEM contents arrive in WB as a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbQ <= '0;
    end else if (stall_mem) begin
      wbQ.valid <= 1'b0;
    end else begin
      wbQ.valid    <= memQ.valid & ~misalign;
      wbQ.rd       <= memQ.rd;
      wbQ.regWrite <= memQ.regWrite;
      wbQ.data     <= memQ.memRead ? loadData : memQ.alu;
    end
  end

  assign rdAddr_wb   = wbQ.rd;
  assign RegWrite_wb = wbQ.valid & wbQ.regWrite;
  assign wb_data     = wbQ.data;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe.
module tb_mem_wb_pipe;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_mem;
  logic        misalign;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem;
  logic [31:0] fwd_mem_data;
  logic [4:0]  rdAddr_wb;
  logic        RegWrite_wb;
  logic [31:0] wb_data;

  int passCount = 0;
  int checkCount = 0;

  mem_wb_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall_mem(stall_mem), .misalign(misalign),
    .rdAddr_mem(rdAddr_mem), .RegWrite_mem(RegWrite_mem), .fwd_mem_data(fwd_mem_data),
    .rdAddr_wb(rdAddr_wb), .RegWrite_wb(RegWrite_wb), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic rdEn,
                       input logic wrEn, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] sd);
    ex_valid = v; ex_rd_addr = rd; ex_reg_write = rw; ex_mem_read = rdEn;
    ex_mem_write = wrEn; ex_funct3 = f3; ex_alu_result = alu; ex_store_data = sd;
  endtask

  task automatic bubble();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    bubble();
    #2;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_mem), 32'd0);
    chk("rst_rwmem", 32'(RegWrite_mem), 32'd0);
    chk("rst_rwwb", 32'(RegWrite_wb), 32'd0);
    chk("rst_wbdata", wb_data, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD rd=5 -> 0x1234
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0);
    tick();
    bubble();
    #1;
    chk("add_rwmem", 32'(RegWrite_mem), 32'd1);
    chk("add_rdmem", 32'(rdAddr_mem), 32'd5);
    chk("add_fwd", fwd_mem_data, 32'h0000_1234);
    chk("add_req", 32'(dmem_req), 32'd0);
    tick();
    chk("add_rwwb", 32'(RegWrite_wb), 32'd1);
    chk("add_rdwb", 32'(rdAddr_wb), 32'd5);
    chk("add_wbdata", wb_data, 32'h0000_1234);
    chk("add_rwmem_gone", 32'(RegWrite_mem), 32'd0);
    tick();

    // LB rd=6 addr 0x103, memory ready on the fourth cycle
    drive(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    tick();
    bubble();
    #1;
    chk("lb_req", 32'(dmem_req), 32'd1);
    chk("lb_stall1", 32'(stall_mem), 32'd1);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_we", 32'(dmem_we), 32'd0);
    tick();
    chk("lb_stall2", 32'(stall_mem), 32'd1);
    chk("lb_wbbubble2", 32'(RegWrite_wb), 32'd0);
    tick();
    chk("lb_stall3", 32'(stall_mem), 32'd1);
    chk("lb_wbbubble3", 32'(RegWrite_wb), 32'd0);
    chk("lb_addr_hold", dmem_addr, 32'h0000_0100);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80FF_FF00;
    #1;
    chk("lb_stall_rel", 32'(stall_mem), 32'd0);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("lb_wbdata", wb_data, 32'hFFFF_FF80);
    chk("lb_rwwb", 32'(RegWrite_wb), 32'd1);
    chk("lb_rdwb", 32'(rdAddr_wb), 32'd6);
    chk("lb_req_done", 32'(dmem_req), 32'd0);

    // SH addr 0x102 data 0xABCD
    drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD);
    tick();
    bubble();
    #1;
    chk("sh_req", 32'(dmem_req), 32'd1);
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", dmem_addr, 32'h0000_0100);
    dmem_ready = 1'b1;
    #1;
    chk("sh_stall", 32'(stall_mem), 32'd0);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("sh_rwwb", 32'(RegWrite_wb), 32'd0);
    chk("sh_req_done", 32'(dmem_req), 32'd0);

    // LW misaligned addr 0x101
    drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
    tick();
    bubble();
    #1;
    chk("lwmis_req", 32'(dmem_req), 32'd0);
    chk("lwmis_pulse", 32'(misalign), 32'd1);
    chk("lwmis_rwmem", 32'(RegWrite_mem), 32'd0);
    chk("lwmis_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("lwmis_pulse_end", 32'(misalign), 32'd0);
    chk("lwmis_rwwb", 32'(RegWrite_wb), 32'd0);

    // LW rd=8 @0x200 then LHU rd=9 @0x206, each ready on first cycle
    drive(1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0206, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1122_3344;
    #1;
    chk("b2b_req1", 32'(dmem_req), 32'd1);
    chk("b2b_addr1", dmem_addr, 32'h0000_0200);
    chk("b2b_stall1", 32'(stall_mem), 32'd0);
    tick();
    bubble();
    dmem_rdata = 32'h8765_4321;
    #1;
    chk("b2b_req2", 32'(dmem_req), 32'd1);
    chk("b2b_addr2", dmem_addr, 32'h0000_0204);
    chk("b2b_wb1", wb_data, 32'h1122_3344);
    chk("b2b_rd1", 32'(rdAddr_wb), 32'd8);
    chk("b2b_rw1", 32'(RegWrite_wb), 32'd1);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("b2b_wb2", wb_data, 32'h0000_8765);
    chk("b2b_rd2", 32'(rdAddr_wb), 32'd9);
    chk("b2b_rw2", 32'(RegWrite_wb), 32'd1);
    chk("b2b_req_done", 32'(dmem_req), 32'd0);

    // Reset while a load is outstanding
    drive(1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
    tick();
    bubble();
    #1;
    chk("rstm_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstm_req", 32'(dmem_req), 32'd0);
    chk("rstm_stall", 32'(stall_mem), 32'd0);
    chk("rstm_rwmem", 32'(RegWrite_mem), 32'd0);
    chk("rstm_rdmem", 32'(rdAddr_mem), 32'd0);
    chk("rstm_rwwb", 32'(RegWrite_wb), 32'd0);
    chk("rstm_wbdata", wb_data, 32'h0);
    chk("rstm_addr", dmem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("late_req", 32'(dmem_req), 32'd0);
    chk("late_stall", 32'(stall_mem), 32'd0);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("late_rwwb", 32'(RegWrite_wb), 32'd0);
    chk("late_wbdata", wb_data, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
